// File: rtl/arbiter_rr.sv
// Two-requester round-robin arbiter with registered one-hot-or-zero grant,
// grant hold while requested, and a bounded tenure under contention.
module arbiter_rr #(
    parameter int MAX_GRANT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] request,
    output logic [1:0] grant,
    output logic       last_grant,
    output logic       preempt
);

    localparam int CW = $clog2(MAX_GRANT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_GRANT_CYCLES);
    localparam logic [CW-1:0] CNT_THRESH = CW'(MAX_GRANT_CYCLES - 1);

    // Encoding matches the grant vector so the output decodes straight from state.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   hold_cnt, hold_cnt_nxt;
    logic            last_nxt;
    logic            preempt_nxt;
    logic            owner;
    logic            other;

    function automatic state_t grant_state(input logic idx);
        return idx ? GRANT1 : GRANT0;
    endfunction

    assign owner = (state == GRANT1);
    assign other = ~owner;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        last_nxt     = last_grant;
        preempt_nxt  = 1'b0;

        case (state)
            IDLE: begin
                case (request)
                    2'b01:   state_nxt = GRANT0;
                    2'b10:   state_nxt = GRANT1;
                    2'b11:   state_nxt = grant_state(~last_grant);
                    default: state_nxt = IDLE;
                endcase
            end
            GRANT0, GRANT1: begin
                if (!request[owner]) begin
                    // Release wins over preemption, so a handoff never pulses preempt.
                    state_nxt = request[other] ? grant_state(other) : IDLE;
                end else if (request[other] && (hold_cnt >= CNT_THRESH)) begin
                    // >= lets a saturated uncontended owner be preempted at once.
                    state_nxt   = grant_state(other);
                    preempt_nxt = 1'b1;
                end else if (hold_cnt != CNT_MAX) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if ((state_nxt != IDLE) && (state_nxt != state)) begin
            hold_cnt_nxt = '0;
            last_nxt     = (state_nxt == GRANT1);
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_grant <= 1'b1;
            preempt    <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            last_grant <= last_nxt;
            preempt    <= preempt_nxt;
        end
    end

    assign grant = state;

endmodule

// File: tb/tb_arbiter_rr.sv
// Self-checking bench for arbiter_rr: two instances (tenure 8 and tenure 1)
// compared every cycle against a tenure-counting reference model.
module tb_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req8, req1;
    logic [1:0] grant8, grant1;
    logic       last8, last1;
    logic       pre8, pre1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner (-1 = nobody), cycles held so far, last owner, preempt flag.
    int m_owner[2];
    int m_held[2];
    int m_last[2];
    int m_pre[2];

    arbiter_rr #(.MAX_GRANT_CYCLES(8)) dut8 (
        .clk(clk), .rst(rst), .request(req8),
        .grant(grant8), .last_grant(last8), .preempt(pre8)
    );

    arbiter_rr #(.MAX_GRANT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .request(req1),
        .grant(grant1), .last_grant(last1), .preempt(pre1)
    );

    always #5 clk = ~clk;

    function automatic int max_of(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_last[k]  = 1;
            m_pre[k]   = 0;
        end
    endfunction

    function automatic void model_enter(input int k, input int idx, input int pre);
        m_owner[k] = idx;
        m_held[k]  = 1;
        m_last[k]  = idx;
        m_pre[k]   = pre;
    endfunction

    // One clock edge of the arbitration rules, on tenure length in whole cycles.
    function automatic void model_edge(input int k, input logic [1:0] r);
        int n, o;
        if (m_owner[k] < 0) begin
            m_pre[k] = 0;
            if (r == 2'b01)      model_enter(k, 0, 0);
            else if (r == 2'b10) model_enter(k, 1, 0);
            else if (r == 2'b11) model_enter(k, 1 - m_last[k], 0);
        end else begin
            n = m_owner[k];
            o = 1 - n;
            if (!r[n]) begin
                if (r[o]) model_enter(k, o, 0);
                else begin
                    m_owner[k] = -1;
                    m_pre[k]   = 0;
                end
            end else if (r[o] && (m_held[k] >= max_of(k))) begin
                model_enter(k, o, 1);
            end else begin
                m_held[k] = m_held[k] + 1;
                m_pre[k]  = 0;
            end
        end
    endfunction

    function automatic logic [3:0] expect_of(input int k);
        logic [1:0] g;
        g = (m_owner[k] < 0) ? 2'b00 : ((m_owner[k] == 0) ? 2'b01 : 2'b10);
        return {g, 1'(m_last[k]), 1'(m_pre[k])};
    endfunction

    // Advance one clock: model follows the edge, outputs are then read at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge(0, req8);
        model_edge(1, req1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req8 = 2'b00;
        req1 = 2'b00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({grant8, last8, pre8} !== 4'b0010) begin
            n_err++;
            $display("FAIL reset8: got {grant,last,preempt}=%b want 0010", {grant8, last8, pre8});
        end
        n_vec++;
        if ({grant1, last1, pre1} !== 4'b0010) begin
            n_err++;
            $display("FAIL reset1: got {grant,last,preempt}=%b want 0010", {grant1, last1, pre1});
        end
    endtask

    task automatic test_single();
        req8 = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            step();
            n_vec++;
            if ({grant8, last8, pre8} !== 4'b0100) begin
                n_err++;
                $display("FAIL single cyc%0d: got %b want 0100", i, {grant8, last8, pre8});
            end
        end
        req8 = 2'b00;
        step();
        n_vec++;
        if ({grant8, last8, pre8} !== expect_of(0) || grant8 !== 2'b00) begin
            n_err++;
            $display("FAIL single_release: got %b want %b", {grant8, last8, pre8}, expect_of(0));
        end
    endtask

    task automatic test_contention();
        logic [1:0] want;
        do_reset();
        req8 = 2'b11;
        for (int i = 1; i <= 40; i++) begin
            step();
            // Owner alternates every 8 cycles starting with requester 0.
            want = (((i - 1) / 8) % 2 == 0) ? 2'b01 : 2'b10;
            n_vec++;
            if (grant8 !== want || pre8 !== ((i > 1) && ((i - 1) % 8 == 0))) begin
                n_err++;
                $display("FAIL contention cyc%0d: got grant=%b preempt=%b want grant=%b", i, grant8, pre8, want);
            end
            n_vec++;
            if ({grant8, last8, pre8} !== expect_of(0)) begin
                n_err++;
                $display("FAIL contention_model cyc%0d: got %b want %b", i, {grant8, last8, pre8}, expect_of(0));
            end
        end
    endtask

    task automatic test_handoff();
        req8 = 2'b00;
        step();
        req8 = 2'b01;
        step();
        req8 = 2'b11;
        step();
        step();
        req8 = 2'b10;
        step();
        n_vec++;
        if ({grant8, last8, pre8} !== 4'b1010) begin
            n_err++;
            $display("FAIL handoff: got %b want 1010", {grant8, last8, pre8});
        end
    endtask

    task automatic test_late_contender();
        req8 = 2'b00;
        step();
        req8 = 2'b01;
        for (int i = 0; i < 30; i++) step();
        n_vec++;
        if ({grant8, last8, pre8} !== 4'b0100) begin
            n_err++;
            $display("FAIL late_hold: got %b want 0100", {grant8, last8, pre8});
        end
        req8 = 2'b11;
        step();
        n_vec++;
        if ({grant8, last8, pre8} !== 4'b1011) begin
            n_err++;
            $display("FAIL late_preempt: got %b want 1011", {grant8, last8, pre8});
        end
        step();
        n_vec++;
        if (pre8 !== 1'b0) begin
            n_err++;
            $display("FAIL late_pulse: got preempt=%b want 0", pre8);
        end
    endtask

    task automatic test_max1();
        do_reset();
        req1 = 2'b11;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_vec++;
            if (grant1 !== ((i % 2 == 1) ? 2'b01 : 2'b10) || pre1 !== (i > 1)) begin
                n_err++;
                $display("FAIL max1 cyc%0d: got grant=%b preempt=%b", i, grant1, pre1);
            end
        end
        // Owner is 1 after an even count; it releases while its tenure is also up.
        req1 = 2'b01;
        step();
        n_vec++;
        if ({grant1, last1, pre1} !== 4'b0100) begin
            n_err++;
            $display("FAIL max1_release: got %b want 0100", {grant1, last1, pre1});
        end
    endtask

    task automatic test_async_reset();
        req8 = 2'b11;
        req1 = 2'b11;
        step();
        step();
        n_vec++;
        if (pre1 !== 1'b1 || grant1 === 2'b00) begin
            n_err++;
            $display("FAIL pre_reset_state: got grant=%b preempt=%b want busy grant, preempt=1", grant1, pre1);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if ({grant8, last8, pre8, grant1, last1, pre1} !== 8'b0010_0010) begin
            n_err++;
            $display("FAIL async_reset: got %b want 00100010", {grant8, last8, pre8, grant1, last1, pre1});
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_vec++;
        if ({grant8, last8, pre8, grant1, last1, pre1} !== 8'b0100_0100) begin
            n_err++;
            $display("FAIL post_reset: got %b want 01000100", {grant8, last8, pre8, grant1, last1, pre1});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(3) == 0) req8[b] = ~req8[b];
                if ($urandom_range(3) == 0) req1[b] = ~req1[b];
            end
            step();
            n_vec++;
            if ({grant8, last8, pre8} !== expect_of(0)) begin
                n_err++;
                $display("FAIL random8 it%0d: req=%b got %b want %b", i, req8, {grant8, last8, pre8}, expect_of(0));
            end
            n_vec++;
            if ({grant1, last1, pre1} !== expect_of(1)) begin
                n_err++;
                $display("FAIL random1 it%0d: req=%b got %b want %b", i, req1, {grant1, last1, pre1}, expect_of(1));
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        req8 = 2'b00;
        req1 = 2'b00;
        test_reset();
        test_single();
        test_contention();
        test_handoff();
        test_late_contender();
        test_max1();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
